// File: rtl/cadence_meas.sv
// rtl/cadence_meas.sv - crank period measurement with 4-sample running average
// and a not-pedaling timeout.
module cadence_meas #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cadence_rise,
    output logic [7:0] cadence_per,
    output logic       cadence_vld,
    output logic       not_pedaling
);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        FIRST   = 2'd1,
        RUNNING = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] per_cnt_q, per_cnt_d;
    logic [7:0]  hist_q [4];
    logic [7:0]  hist_d [4];
    logic [7:0]  per_q, per_d;
    logic        vld_q, vld_d;
    logic        np_q, np_d;

    logic        sat;
    logic [7:0]  sample;
    logic [9:0]  sum;

    // The fast window lets simulation reach saturation in 64K clocks.
    always_comb begin
        sat    = FAST_SIM ? (&per_cnt_q[15:0]) : (&per_cnt_q);
        sample = FAST_SIM ? per_cnt_q[15:8] : per_cnt_q[23:16];
        sum    = 10'(sample) + 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]);
    end

    always_comb begin
        per_cnt_d = per_cnt_q;
        if (cadence_rise) begin
            per_cnt_d = '0;
        end else if (!sat) begin
            per_cnt_d = per_cnt_q + 24'd1;
        end
    end

    // A rise always wins over saturation, so a saturated sample is still accepted.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        per_d   = per_q;
        vld_d   = 1'b0;
        case (state_q)
            STOPPED: begin
                if (cadence_rise) begin
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (cadence_rise) begin
                    state_d = RUNNING;
                    hist_d  = '{sample, sample, sample, sample};
                    per_d   = sample;
                    vld_d   = 1'b1;
                end else if (sat) begin
                    state_d = STOPPED;
                end
            end
            RUNNING: begin
                if (cadence_rise) begin
                    hist_d[0] = sample;
                    hist_d[1] = hist_q[0];
                    hist_d[2] = hist_q[1];
                    hist_d[3] = hist_q[2];
                    per_d     = sum[9:2];
                    vld_d     = 1'b1;
                end else if (sat) begin
                    state_d = STOPPED;
                    hist_d  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
                    per_d   = 8'hFF;
                end
            end
            default: begin
                state_d = STOPPED;
            end
        endcase
        np_d = (state_d != RUNNING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STOPPED;
            per_cnt_q <= '0;
            hist_q    <= '{default: 8'hFF};
            per_q     <= 8'hFF;
            vld_q     <= 1'b0;
            np_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hist_q    <= hist_d;
            per_q     <= per_d;
            vld_q     <= vld_d;
            np_q      <= np_d;
        end
    end

    assign cadence_per  = per_q;
    assign cadence_vld  = vld_q;
    assign not_pedaling = np_q;

endmodule

// File: tb/tb_cadence_meas.sv
// tb/tb_cadence_meas.sv - directed and randomized checks of cadence_meas
// against a rise-to-rise period model.
module tb_cadence_meas;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cadence_rise;
    logic [7:0] cadence_per;
    logic       cadence_vld;
    logic       not_pedaling;

    int vectors     = 0;
    int miscompares = 0;

    // Model: elapsed clocks since the last rise, capped at the 16-bit window.
    int m_cnt;
    int m_mode;      // 0 idle, 1 one rise seen, 2 measuring
    int m_hist[$];
    int m_per;
    bit m_vld;

    int exp3[4] = '{10, 12, 14, 16};

    cadence_meas #(.FAST_SIM(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence_rise (cadence_rise),
        .cadence_per  (cadence_per),
        .cadence_vld  (cadence_vld),
        .not_pedaling (not_pedaling)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_per"}, cadence_per, m_per[7:0]);
        check({tag, "_vld"}, {7'd0, cadence_vld}, {7'd0, m_vld});
        check({tag, "_np"}, {7'd0, not_pedaling}, (m_mode != 2) ? 8'd1 : 8'd0);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_mode = 0;
        m_hist = '{255, 255, 255, 255};
        m_per  = 255;
        m_vld  = 1'b0;
    endtask

    task automatic model_edge(input bit r);
        int s;
        s     = m_cnt / 256;
        m_vld = 1'b0;
        if (r) begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                m_hist = '{s, s, s, s};
                m_per  = s;
                m_vld  = 1'b1;
                m_mode = 2;
            end else begin
                m_per = (s + m_hist[0] + m_hist[1] + m_hist[2]) / 4;
                m_hist.push_front(s);
                void'(m_hist.pop_back());
                m_vld = 1'b1;
            end
            m_cnt = 0;
        end else if (m_cnt == 65535) begin
            if (m_mode == 2) begin
                m_hist = '{255, 255, 255, 255};
                m_per  = 255;
            end
            m_mode = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic tick(input bit r, input string tag);
        cadence_rise = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_all(tag);
    endtask

    task automatic gap(input int n, input string tag);
        repeat (n) tick(1'b0, tag);
        tick(1'b1, tag);
    endtask

    task automatic preload_count(input logic [23:0] v);
        force dut.per_cnt_q = v;
        #1;
        release dut.per_cnt_q;
        m_cnt = int'(v);
    endtask

    initial begin
        rst_n        = 1'b0;
        cadence_rise = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (100) tick(1'b0, "t1_idle");

        tick(1'b1, "t2_first");
        gap(2048, "t2");
        check("t2_per_const", cadence_per, 8'h08);
        check("t2_vld_const", {7'd0, cadence_vld}, 8'd1);
        check("t2_np_const", {7'd0, not_pedaling}, 8'd0);

        for (int i = 0; i < 4; i++) begin
            gap(4096, "t3");
            check("t3_per_const", cadence_per, exp3[i][7:0]);
        end

        preload_count(24'h00FFF0);
        repeat (15) tick(1'b0, "t5_approach");
        tick(1'b1, "t5_sat_rise");
        check("t5_per_const", cadence_per, 8'h4B);
        check("t5_vld_const", {7'd0, cadence_vld}, 8'd1);
        check("t5_np_const", {7'd0, not_pedaling}, 8'd0);

        preload_count(24'h00FFF0);
        repeat (16) tick(1'b0, "t4_timeout");
        check("t4_per_const", cadence_per, 8'hFF);
        check("t4_np_const", {7'd0, not_pedaling}, 8'd1);
        tick(1'b1, "t4_lone");
        check("t4_lone_vld_const", {7'd0, cadence_vld}, 8'd0);

        gap(2048, "t6_pre");
        gap(4096, "t6_pre");
        repeat (37) tick(1'b0, "t6_pre");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        check("t6_per_const", cadence_per, 8'hFF);
        @(negedge clk);
        check_all("t6_held");
        rst_n = 1'b1;
        tick(1'b1, "t6_first");
        gap(2048, "t6_rec");
        check("t6_rec_per_const", cadence_per, 8'h08);

        repeat (30) gap(int'($urandom_range(0, 1500)), "rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
